// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command/payload frames and serialises
// an 8-bit readback byte after a read-data command frame.
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MOSI,
  input  logic       SS_n,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e     r_state;
  logic [8:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_frame_done;
  logic       r_rd_addr_done;
  logic       r_tx_loaded;
  logic [7:0] r_tx_shift;
  logic [3:0] r_tx_cnt;
  logic       r_miso;
  logic       r_rx_valid;
  logic [9:0] r_rx_data;

  logic [9:0] w_frame;
  logic       w_last_bit;

  // The bit on MOSI this edge completes the frame when the counter has reached 9.
  assign w_frame    = {r_shift, MOSI};
  assign w_last_bit = (r_bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_frame_done   <= 1'b0;
      r_rd_addr_done <= 1'b0;
      r_tx_loaded    <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_miso         <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_data      <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (SS_n) begin
        // Deselect aborts any partial frame; captured data and rd_addr_done survive.
        r_state      <= StIdle;
        r_bit_cnt    <= '0;
        r_tx_cnt     <= '0;
        r_frame_done <= 1'b0;
        r_tx_loaded  <= 1'b0;
        r_tx_shift   <= '0;
        r_miso       <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_state <= StChkCmd;
          end
          StChkCmd: begin
            r_shift   <= {8'd0, MOSI};
            r_bit_cnt <= 4'd1;
            if (!MOSI) begin
              r_state <= StWrite;
            end else if (r_rd_addr_done) begin
              r_state <= StReadData;
            end else begin
              r_state <= StReadAdd;
            end
          end
          StWrite, StReadAdd, StReadData: begin
            if (!r_frame_done) begin
              r_shift <= w_frame[8:0];
              if (w_last_bit) begin
                r_rx_data    <= w_frame;
                r_rx_valid   <= 1'b1;
                r_frame_done <= 1'b1;
                r_bit_cnt    <= '0;
                if (r_state == StReadAdd) begin
                  r_rd_addr_done <= 1'b1;
                end else if (r_state == StReadData) begin
                  r_rd_addr_done <= 1'b0;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end else if (r_state == StReadData) begin
              // Completed frames hold here, ignoring MOSI, until SS_n rises.
              if (!r_tx_loaded && tx_valid) begin
                r_tx_loaded <= 1'b1;
                r_miso      <= tx_data[7];
                r_tx_shift  <= {tx_data[6:0], 1'b0};
                r_tx_cnt    <= 4'd7;
              end else if (r_tx_cnt != 4'd0) begin
                r_miso     <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_tx_cnt   <= r_tx_cnt - 4'd1;
              end else begin
                r_miso <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter none; the frame width is fixed at 10 bits and the readback width at 8 bits.
REQ-002 SHALL have port clk, input, 1 bit: SPI serial clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port MOSI, input, 1 bit: master-out serial data, MSB first.
REQ-005 SHALL have port SS_n, input, 1 bit: active-low slave select; a frame is valid only while it is low.
REQ-006 SHALL have port MISO, output, 1 bit: slave-out serial data, MSB first.
REQ-007 SHALL have port rx_data, output, 10 bits: last complete frame; [9:8] = command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] = payload.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle strobe that rx_data has just updated.
REQ-009 SHALL have port tx_data, input, 8 bits: readback byte from the downstream memory.
REQ-010 SHALL have port tx_valid, input, 1 bit: tx_data is valid.

Function
REQ-011 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 SHALL move IDLE -> CHK_CMD on an edge with SS_n=0; otherwise it SHALL remain in IDLE.
REQ-013 SHALL treat the edge leaving CHK_CMD as frame bit 0: MOSI is shifted in as frame bit 9 and also selects the next state.
REQ-014 SHALL select the next state from CHK_CMD as: MOSI=0 -> WRITE; MOSI=1 with rd_addr_done=0 -> READ_ADD; MOSI=1 with rd_addr_done=1 -> READ_DATA.
REQ-015 SHALL, in WRITE/READ_ADD/READ_DATA, shift MOSI into a 10-bit register on each edge, with a 4-bit counter tracking bits 1..9.
REQ-016 SHALL, on the edge sampling frame bit 9, register the full frame into rx_data and assert rx_valid for exactly the following cycle.
REQ-017 SHALL leave rx_data unchanged until the next complete frame.
REQ-018 SHALL pass command bits [9:8] exactly as received, with no checking against the state.
REQ-019 SHALL set rd_addr_done on completion of a READ_ADD frame and clear it on completion of a READ_DATA frame.
REQ-020 SHALL return WRITE and READ_ADD to IDLE after frame completion, or stay in the state until SS_n=1.
REQ-021 SHALL, in READ_DATA after the frame completes, load tx_data into an 8-bit output shifter on the first edge with tx_valid=1; that load happens at most once per frame.
REQ-022 SHALL drive MISO = tx_data[7] in the cycle after the load, then one bit per edge down to tx_data[0] (8 cycles total).
REQ-023 SHALL hold MISO=0 afterwards and in every other state.
REQ-024 SHALL ignore tx_valid outside READ_DATA and before its frame completes.
REQ-025 SHALL move any state to IDLE on an edge with SS_n=1.
REQ-026 SHALL on SS_n=1 clear both counters, discard a partial frame (no rx_valid, rx_data and rd_addr_done unchanged) and force MISO to 0.
REQ-027 SHALL require a new SS_n low period for each frame; back-to-back frames need at least one SS_n=1 edge between them.

Reset
REQ-028 SHALL on rst_n=0, immediately and independent of clk: state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, counters=0, output shifter=0.
REQ-029 SHALL treat reset mid-frame as aborting the frame with no rx_valid; operation resumes from IDLE after rst_n=1.

Verification
REQ-030 SHALL cover: SS_n low, MOSI bits 00_1010_0101 -> rx_data=0x0A5, rx_valid high for 1 cycle after the 10th bit, MISO=0 throughout.
REQ-031 SHALL cover: frame 10_0011_0000 then frame 11_xxxx_xxxx, with tx_valid=1 and tx_data=0xC3 -> rd_addr_done 1 then 0; MISO serially 1,1,0,0,0,0,1,1.
REQ-032 SHALL cover: 11-prefixed frame with rd_addr_done=0 -> FSM takes READ_ADD; rx_data[9:8]=11, rx_valid pulses, MISO stays 0.
REQ-033 SHALL cover: SS_n raised after 6 bits -> no rx_valid, rx_data retains its prior value; the next full frame decodes correctly.
REQ-034 SHALL cover: rst_n pulsed low mid-READ_DATA shift-out -> MISO=0 and rx_valid=0 immediately, rd_addr_done=0, next 10-bit frame decodes correctly.
